// File: rtl/tx_frame_ctrl.sv
// Transmit frame controller: one-deep holding buffer, 11-bit UART frame builder,
// and load/shift-enable strobe generation for the downstream PISO shift register.
module tx_frame_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             wr,
  input  logic [7:0]       din,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic [CNT_W-1:0] baud_k,
  input  logic             clr_ovr,
  output logic             ld,
  output logic             sh_en,
  output logic [10:0]      frame_out,
  output logic             ser_fill,
  output logic             tx_rdy,
  output logic             tx_done,
  output logic             busy,
  output logic             ovr
);

  // state | meaning
  // INIT  | first cycle out of reset, load all-ones so the line idles at mark
  // IDLE  | waiting for the holding buffer to fill
  // LOAD  | one-cycle load of the built frame, buffer released
  // SHIFT | 11 bit periods of k cycles, one sh_en per period
  typedef enum logic [1:0] {INIT, IDLE, LOAD, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] k_m1;
  logic [3:0]       bitcnt;
  logic [7:0]       hold;
  logic [10:0]      frame_q;
  logic [10:0]      frame_new;
  logic             par;
  logic             tc;

  assign ser_fill = 1'b1;

  always_comb begin
    k_m1      = (baud_k == '0) ? '0 : baud_k - CNT_W'(1);
    tc        = (timer == k_m1);
    par       = 1'b1;
    if (pen) par = (eight ? ^hold : ^hold[6:0]) ^ ohel;
    frame_new = eight ? {1'b1, par, hold, 1'b0}
                      : {2'b11, par, hold[6:0], 1'b0};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    sh_en     = 1'b0;
    tx_done   = 1'b0;
    busy      = 1'b0;
    frame_out = frame_q;
    case (state)
      INIT: begin
        // INIT is also the reset state; keep ld quiet while reset is held
        ld        = ~Rst;
        frame_out = 11'h7FF;
        state_nxt = IDLE;
      end
      IDLE: begin
        if (!tx_rdy) state_nxt = LOAD;
      end
      LOAD: begin
        ld        = 1'b1;
        busy      = 1'b1;
        frame_out = frame_new;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (tc) begin
          sh_en = 1'b1;
          if (bitcnt == 4'd10) begin
            tx_done   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      timer   <= '0;
      bitcnt  <= '0;
      frame_q <= 11'h7FF;
    end else begin
      frame_q <= frame_out;
      if (state == LOAD) begin
        timer  <= '0;
        bitcnt <= '0;
      end else if (state == SHIFT) begin
        if (tc) begin
          timer  <= '0;
          bitcnt <= bitcnt + 4'd1;
        end else begin
          timer <= timer + CNT_W'(1);
        end
      end
    end
  end

  // LOAD always sees tx_rdy=0, so a write there falls into the overrun branch
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hold   <= '0;
      tx_rdy <= 1'b1;
      ovr    <= 1'b0;
    end else begin
      if (wr && tx_rdy) begin
        hold   <= din;
        tx_rdy <= 1'b0;
      end else if (state == LOAD) begin
        tx_rdy <= 1'b1;
      end
      if (wr && !tx_rdy)  ovr <= 1'b1;
      else if (clr_ovr)   ovr <= 1'b0;
    end
  end

endmodule

// File: doc/tx_frame_ctrl.md
Name: tx_frame_ctrl

Overview:
Transmit-side controller that sits directly upstream of the 11-bit parallel-in/serial-out transmit shift register. It accepts bytes from the processor interface into a one-deep holding buffer and builds the 11-bit UART frame (start, data, parity/stop). It generates the load and shift-enable strobes that drive the shift register at the programmed bit rate, and reports ready, done and overrun status to the status register.

Parameters:
CNT_W, 16, width of the bit-period divisor input and the internal bit timer.

Ports:
Clk  input  1  system clock, rising edge.
Rst  input  1  asynchronous, active-high reset (top level inverts it for the shift register's active-low reset).
wr  input  1  one-cycle write strobe for din.
din  input  8  transmit byte.
eight  input  1  1 = 8 data bits, 0 = 7 data bits (din[7] ignored).
pen  input  1  parity enable.
ohel  input  1  parity sense: 1 = odd, 0 = even.
baud_k  input  CNT_W  bit period in Clk cycles; 0 is treated as 1.
clr_ovr  input  1  clears ovr.
ld  output  1  load strobe to shift register.
sh_en  output  1  shift-enable strobe to shift register.
frame_out  output  11  frame presented to shift register data_in; bit0 goes on the line first.
ser_fill  output  1  serial fill bit to shift register; constant 1 (idle mark).
tx_rdy  output  1  holding buffer empty.
tx_done  output  1  one-cycle pulse when a frame completes.
busy  output  1  frame in progress.
ovr  output  1  sticky overrun flag.

Behaviour:
- Reset values (async, while Rst=1): state INIT, ld=0, sh_en=0, frame_out=11'h7FF, tx_rdy=1, tx_done=0, busy=0, ovr=0, timer=0, bitcnt=0, holding buffer cleared.
- FSM states: INIT, IDLE, LOAD, SHIFT.
- INIT (first cycle after Rst falls): ld=1 with frame_out=11'h7FF, so the line idles at mark. Next state IDLE.
- IDLE: ld=0, sh_en=0, busy=0. If the buffer is full, go to LOAD.
- LOAD: ld=1 for exactly one cycle.
  - frame_out is built from the buffer and from eight, pen and ohel sampled in this cycle.
  - Buffer is freed: tx_rdy=1 from the next cycle. timer=0, bitcnt=0, busy=1.
  - Next state SHIFT.
- Frame format, bit0 first:
  - 8-bit: {1, P, d[7:0], 0}.
  - 7-bit: {1, 1, P, d[6:0], 0}.
  - P = ^data XOR ohel when pen=1; P = 1 when pen=0.
- SHIFT: timer increments each cycle.
  - When timer == k-1 (k = max(baud_k, 1)): sh_en=1 for that cycle, timer<=0, bitcnt<=bitcnt+1.
  - On the 11th sh_en (bitcnt==10): tx_done=1 in that cycle, next state IDLE.
  - Every bit is held on the line exactly k cycles. The 11th shift brings in ser_fill=1, so the line stays at mark.
  - Frame length: 11k SHIFT cycles. Back-to-back ld spacing is 11k+2 cycles (LOAD, 11k SHIFT, IDLE).
- ld and sh_en are decoded from registered state and timer, and are never asserted in the same cycle.
- frame_out holds its value from LOAD until the next LOAD or INIT.
- baud_k changes mid-frame take effect at the next compare. A value below the current timer wraps at 2^CNT_W; software must change baud_k only while busy=0.
- Holding buffer and write handshake:
  - wr while tx_rdy=1: din is captured and tx_rdy=0 next cycle.
  - wr while tx_rdy=0: data is dropped, buffer is unchanged, ovr=1 next cycle.
  - wr in the LOAD cycle counts as an overrun, because tx_rdy is still 0 in that cycle.
  - wr while SHIFT is active is accepted if tx_rdy=1 (double buffering).
- ovr: sticky. clr_ovr clears it. If clr_ovr and a new overrun occur in the same cycle, the set wins.
- Rst mid-frame: all state clears immediately. INIT then re-marks the line; any partial frame is abandoned and not reported as done.

Test Plan:
1. Reset release, k=4 -> one ld pulse with frame_out=11'h7FF in the first cycle; tx_rdy=1, busy=0, ovr=0.
2. eight=1, pen=0, wr din=8'hA5, k=4 -> ld two cycles after wr with frame_out=11'b11_10100101_0; exactly 11 sh_en pulses spaced 4 cycles apart; tx_done coincides with the 11th; busy falls.
3. eight=1, pen=1, ohel=0, din=8'h07 -> P=1, frame_out=11'b1_1_00000111_0. Repeat with ohel=1 -> P=0. With eight=0, din=8'h85 -> data bits 7'h05, frame_out[8]=P, frame_out[10:9]=2'b11.
4. Write 8'h11, then write 8'h22 once tx_rdy returns mid-frame -> second ld exactly 11k+2 cycles after the first; ovr stays 0.
5. A third write while the buffer is full -> ovr=1 and the buffered byte is unchanged. clr_ovr -> ovr=0. clr_ovr together with a new overrun -> ovr stays 1.
6. Assert Rst after the 5th sh_en -> outputs return to reset values immediately; after release, INIT ld with 11'h7FF; no tx_done pulse. Also check baud_k=0 behaves as k=1 (sh_en every cycle).
